// File: rtl/hs4_pkg.sv
// Shared types and defaults for the hs4_receiver 4-phase handshake receiver.
package hs4_pkg;

  typedef enum logic [1:0] {
    RECOVER = 2'd0,
    IDLE    = 2'd1,
    HOLD    = 2'd2,
    ACK     = 2'd3
  } hs4_state_t;

  localparam int HS4_DW          = 8;
  localparam int HS4_SYNC_STAGES = 2;

endpackage

// File: rtl/hs4_receiver_sync_nff.sv
// N-flop single-bit synchroniser, async active-low reset to 0.
module sync_nff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign dout = sync_q[N-1];

endmodule

// File: rtl/hs4_receiver.sv
// Receiving end of a 4-phase req/ack handshake, presenting words on a valid/ready stream.
// Optional even-parity check of the received word when HS4_PARITY_EN is defined.
module hs4_receiver
  import hs4_pkg::*;
#(
  parameter int DW          = HS4_DW,
  parameter int SYNC_STAGES = HS4_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [DW-1:0] d,
`ifdef HS4_PARITY_EN
  input  logic          req_par,
  output logic          par_err,
`endif
  output logic          ack,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output hs4_state_t    dbg_state
);

  // Handshake: a word moves to the sink on a rising clk edge where out_valid && out_ready.
  localparam logic [2:0] REC_MAX = 3'(SYNC_STAGES);

  logic          req_s;
  hs4_state_t    state_q, state_d;
  logic          ack_q, ack_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [2:0]    rec_cnt_q, rec_cnt_d;
`ifdef HS4_PARITY_EN
  logic          par_q, par_d;
`endif

  sync_nff #(.N(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst),
    .din   (req),
    .dout  (req_s)
  );

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    valid_d   = valid_q;
    data_d    = data_q;
    rec_cnt_d = rec_cnt_q;
`ifdef HS4_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      RECOVER: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        // The synchroniser is cleared by reset, so req_s only reflects the
        // real pin after it has refilled; wait that long before trusting it.
        if (rec_cnt_q != REC_MAX) rec_cnt_d = rec_cnt_q + 3'd1;
        else if (!req_s)          state_d   = IDLE;
      end
      IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (req_s) begin
          data_d  = d;
          valid_d = 1'b1;
`ifdef HS4_PARITY_EN
          par_d   = (^d) ^ req_par;
`endif
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
`ifdef HS4_PARITY_EN
          par_d   = 1'b0;
`endif
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = RECOVER;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RECOVER;
      ack_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      rec_cnt_q <= '0;
`ifdef HS4_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      rec_cnt_q <= rec_cnt_d;
`ifdef HS4_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign dbg_state = state_q;
`ifdef HS4_PARITY_EN
  assign par_err   = par_q;
`endif

endmodule

// File: tb/tb_hs4_receiver.sv
// Directed bench for hs4_receiver (DW=8, SYNC_STAGES=2); parity steps run when HS4_PARITY_EN is defined.
module tb_hs4_receiver;
  import hs4_pkg::*;

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] d;
  logic       ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  hs4_state_t dbg_state;
`ifdef HS4_PARITY_EN
  logic       req_par;
  logic       par_err;
`endif

  int n_pass;
  int n_total;
  int n_rx;
  int n_ack_rise;
  int n_valid;
  logic       ack_prev;
  logic [7:0] last_word;
  logic [7:0] exp_q[$];
  logic [7:0] words[3];

  hs4_receiver #(.DW(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d         (d),
`ifdef HS4_PARITY_EN
    .req_par   (req_par),
    .par_err   (par_err),
`endif
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Tick while acting as the sink monitor: a word sampled with valid && ready is taken at the next edge.
  task automatic tick_mon;
    if (out_valid && out_ready) begin
      n_rx++;
      if (exp_q.size() > 0) check("b2b_word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      else check("b2b_unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
    end
    tick();
    if (ack && !ack_prev) n_ack_rise++;
    ack_prev = ack;
  endtask

  task automatic wait_ack(input logic level, input string tag);
    int cnt;
    cnt = 0;
    while (ack !== level && cnt < 30) begin
      tick_mon();
      cnt++;
    end
    check(tag, {31'd0, ack}, {31'd0, level});
  endtask

  task automatic reset_release;
    tick(); tick();
    rst = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_rx = 0; n_ack_rise = 0; ack_prev = 1'b0;
    rst = 1'b0; req = 1'b0; d = 8'h00; out_ready = 1'b0;
`ifdef HS4_PARITY_EN
    req_par = 1'b0;
`endif
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_ack", {31'd0, ack}, 32'd0);
    repeat (3) tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, RECOVER});
    rst = 1'b1;
    repeat (4) tick();
    check("idle_after_reset", {30'd0, dbg_state}, {30'd0, IDLE});

    // Simple transfer: valid 3 edges after req, ack on the accept edge, ack drops 3 edges after req falls
    d = 8'hA5; out_ready = 1'b1; req = 1'b1;
    tick(); tick();
    check("t1_valid_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", {24'd0, out_data}, 32'hA5);
    check("t1_ack_before", {31'd0, ack}, 32'd0);
    tick();
    check("t1_valid_one_cycle", {31'd0, out_valid}, 32'd0);
    check("t1_ack", {31'd0, ack}, 32'd1);
    req = 1'b0;
    tick(); tick();
    check("t1_ack_held", {31'd0, ack}, 32'd1);
    tick();
    check("t1_ack_drop", {31'd0, ack}, 32'd0);
    tick();

    // Backpressure
    d = 8'h3C; out_ready = 1'b0; req = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", {24'd0, out_data}, 32'h3C);
      check("bp_ack", {31'd0, ack}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_ack_after_accept", {31'd0, ack}, 32'd1);
    check("bp_valid_after_accept", {31'd0, out_valid}, 32'd0);
    req = 1'b0;
    repeat (3) tick();
    check("bp_ack_drop", {31'd0, ack}, 32'd0);

    // out_ready with nothing valid has no effect
    repeat (4) tick();
    check("idle_ready_valid", {31'd0, out_valid}, 32'd0);
    check("idle_ready_ack", {31'd0, ack}, 32'd0);

    // Req held across reset: stale transfer is ignored, next one delivered once
    rst = 1'b0; d = 8'hEE; req = 1'b1; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) n_valid++;
    end
    check("stale_no_valid", n_valid, 32'd0);
    req = 1'b0;
    repeat (4) tick();
    d = 8'h11; req = 1'b1;
    n_valid = 0; last_word = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) begin n_valid++; last_word = out_data; end
    end
    check("stale_one_word", n_valid, 32'd1);
    check("stale_word_data", {24'd0, last_word}, 32'h11);
    req = 1'b0;
    repeat (4) tick();
    check("stale_ack_drop", {31'd0, ack}, 32'd0);

    // Back-to-back words under a 4-phase sender
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    n_rx = 0; n_ack_rise = 0; ack_prev = ack; out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      d = words[w]; exp_q.push_back(words[w]); req = 1'b1;
      wait_ack(1'b1, "b2b_ack_rise");
      req = 1'b0;
      wait_ack(1'b0, "b2b_ack_fall");
    end
    repeat (6) tick_mon();
    check("b2b_rx_count", n_rx, 32'd3);
    check("b2b_queue_empty", exp_q.size(), 32'd0);
    check("b2b_ack_rises", n_ack_rise, 32'd3);

    // Req drops while HOLD: transfer completes, no second word
    d = 8'h5A; out_ready = 1'b0; req = 1'b1;
    repeat (3) tick();
    req = 1'b0;
    repeat (5) tick();
    check("hold_drop_valid", {31'd0, out_valid}, 32'd1);
    check("hold_drop_data", {24'd0, out_data}, 32'h5A);
    out_ready = 1'b1;
    tick();
    check("hold_drop_ack", {31'd0, ack}, 32'd1);
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) n_valid++;
    end
    check("hold_drop_no_second", n_valid, 32'd0);
    check("hold_drop_ack_low", {31'd0, ack}, 32'd0);

    // Reset mid-HOLD clears outputs before any clock edge
    d = 8'h77; out_ready = 1'b0; req = 1'b1;
    repeat (3) tick();
    check("midrst_valid_before", {31'd0, out_valid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_data", {24'd0, out_data}, 32'd0);
    req = 1'b0;
    reset_release();
    check("midrst_idle", {30'd0, dbg_state}, {30'd0, IDLE});

`ifdef HS4_PARITY_EN
    // Parity: ^8'h07 = 1
    d = 8'h07; req_par = 1'b1; out_ready = 1'b0; req = 1'b1;
    repeat (3) tick();
    check("par_ok_valid", {31'd0, out_valid}, 32'd1);
    check("par_ok_err", {31'd0, par_err}, 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    req = 1'b0;
    repeat (4) tick();
    d = 8'h07; req_par = 1'b0; req = 1'b1;
    repeat (3) tick();
    check("par_bad_err", {31'd0, par_err}, 32'd1);
    tick();
    check("par_bad_err_held", {31'd0, par_err}, 32'd1);
    out_ready = 1'b1; tick();
    check("par_bad_ack", {31'd0, ack}, 32'd1);
    check("par_bad_err_clear", {31'd0, par_err}, 32'd0);
    req = 1'b0;
    repeat (3) tick();
    check("par_bad_ack_drop", {31'd0, ack}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hs4_receiver.md
Name: hs4_receiver

Overview:
- Receiving end of a 4-phase (return-to-zero) req/ack handshake.
- The sending side holds data stable in a level-sensitive latch while req is high. This block synchronises req into its own clock domain, captures the held data, and presents it on a valid/ready stream to a local sink.
- It returns ack once the sink accepts, then completes the return-to-zero phase.
- Sits at clock-domain boundaries between latch-based producers and flop-based consumers.

Parameters:
- DW, 8, width of the transferred data word.
- SYNC_STAGES, 2, flops in the req synchroniser chain. Legal values are 2 to 4.

Ports:
- clk  input  1  single clock for all sequential logic.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  handshake request from the sender, asynchronous to clk.
- d  input  DW  data held stable by the sender while req=1.
- ack  output  1  handshake acknowledge to the sender; registered, glitch-free.
- out_data  output  DW  captured word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  the sink accepts when out_valid && out_ready at a rising clk edge.

Behaviour:
- Reset (rst=0, asynchronous):
  - ack=0, out_valid=0, out_data=0.
  - Synchroniser flops cleared.
  - State goes to RECOVER.
- req_s is req after SYNC_STAGES flops. Only req_s is used; d is sampled only in the cycle the FSM leaves IDLE. The sender guarantees d is stable from before req rises until ack is seen high.
- FSM states and transitions:
  - RECOVER: ack=0. Go to IDLE when req_s=0. This prevents capturing a stale transfer that was in progress across reset.
  - IDLE: ack=0, out_valid=0. If req_s=1, register out_data<=d and out_valid<=1, then go to HOLD.
  - HOLD: out_valid=1 and out_data is stable. On out_valid && out_ready, out_valid<=0, ack<=1, go to ACK.
  - ACK: ack=1. When req_s=0, ack<=0, go to IDLE.
- Latency:
  - req rising at the pin to out_valid=1 is SYNC_STAGES+1 clk edges.
  - Sink accept to ack=1 is 1 edge.
  - req falling to ack=0 is SYNC_STAGES+1 edges.
- Backpressure: out_ready may stay low indefinitely. ack is withheld, so the sender stalls and d remains held.
- Exactly one word is delivered per req high period. A req pulse shorter than SYNC_STAGES+1 cycles may be missed; that is protocol misuse and is not required to be detected.
- If req drops while in HOLD, the transfer still completes. ack rises after accept and falls SYNC_STAGES+1 cycles later; no second word is produced.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-transfer aborts immediately: ack=0 and out_valid=0 asynchronously, then RECOVER.
- Throughput: the minimum cycle per word is about 2*(SYNC_STAGES+1)+2 clocks.

Optional Feature:
- Macro: HS4_PARITY_EN.
- When defined:
  - Extra input req_par (1 bit), the even parity of d, held with d.
  - Extra output par_err (1 bit, reset 0), registered with out_data at capture: par_err = ^d ^ req_par.
  - par_err stays valid alongside out_valid and clears when out_valid drops.
  - The handshake proceeds regardless of par_err.
- When undefined: neither port exists and there is no parity logic.

Decomposition:
- Package hs4_pkg:
  - state enum type hs4_state_t {RECOVER, IDLE, HOLD, ACK} as logic [1:0].
  - Default constants for DW and SYNC_STAGES.
- One sub-module, sync_nff: a parameterised N-flop single-bit synchroniser with async active-low reset to 0. It is instantiated for req.

Test Plan:
- Reset then simple transfer: rst low 3 cycles, then high. req=1 with d=8'hA5, out_ready=1 → out_valid=1 with out_data=8'hA5 exactly 3 edges after req, for 1 cycle. ack=1 on the next edge. Drop req → ack=0 3 edges later.
- Backpressure: d=8'h3C, out_ready=0 for 20 cycles → out_valid and out_data=8'h3C held, ack stays 0. Raise out_ready → ack=1 one edge later.
- Req held across reset: req=1 at reset release → no out_valid while req stays high. Drop req, then a new req with d=8'h11 → a single word 8'h11 is delivered.
- Back-to-back words: 8'h01, 8'h02, 8'h03 under a correct 4-phase sender model → exactly three words received in order, no duplicates, ack toggles three times.
- Reset mid-HOLD: assert rst while out_valid=1 → ack and out_valid go to 0 in the same timestep, before any clk edge.
- Parity (HS4_PARITY_EN defined):
  - d=8'h07 with req_par=1 → par_err=0.
  - d=8'h07 with req_par=0 → par_err=1 while out_valid=1, and the handshake still completes.
